// File: rtl/sva_result_collector.sv
`default_nettype none
// ============================================================================
// Module      : sva_result_collector
// Description : Collects per-evaluation succ / fail / lazy_succ pulses from
//               the SVA evaluator. Keeps saturating per-kind counters, a
//               sticky overall verdict, and a first-word-fall-through FIFO of
//               non-empty events stamped with the gclk period index.
// Revision    : 1.0 - initial release
// ============================================================================
module sva_result_collector #(
    parameter int CNT_W      = 16,
    parameter int PERIOD_W   = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst_n,
    input  logic                          clr,
    input  logic                          gclk_posedge,
    input  logic                          succ,
    input  logic                          fail,
    input  logic                          lazy_succ,
    output logic [CNT_W-1:0]              succ_cnt,
    output logic [CNT_W-1:0]              fail_cnt,
    output logic [CNT_W-1:0]              lazy_cnt,
    output logic [1:0]                    verdict,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [3+PERIOD_W-1:0]         evt_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int DW = 3 + PERIOD_W;

    localparam logic [CNT_W-1:0]    C_CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]    C_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [PERIOD_W-1:0] C_PER_ONE  = {{(PERIOD_W-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0]       C_PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [LW-1:0]       C_LVL_ONE  = {{(LW-1){1'b0}}, 1'b1};
    localparam logic [LW-1:0]       C_LVL_FULL = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        V_NONE    = 2'b00,
        V_PASS    = 2'b01,
        V_FAIL    = 2'b10,
        V_ILLEGAL = 2'b11
    } verdict_t;

    // Event mask: bit0 succ, bit1 lazy_succ, bit2 fail (matches evt_data order)
    logic [2:0]           w_mask;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_wr_en;
    logic [DW-1:0]        w_entry;
    logic [3*CNT_W-1:0]   w_cnt_all;

    logic [PERIOD_W-1:0]  r_period;
    logic [DW-1:0]        r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wptr;
    logic [AW-1:0]        r_rptr;
    logic [LW-1:0]        r_level;
    logic                 r_overflow;
    verdict_t             r_state;
    verdict_t             w_state_nxt;

    assign w_mask  = {fail, lazy_succ, succ};
    assign w_push  = |w_mask;
    assign w_full  = (r_level == C_LVL_FULL);
    assign w_pop   = evt_valid && evt_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign w_wr_en = w_push && (!w_full || w_pop);
    // Stamp with the period value before this cycle's increment
    assign w_entry = {w_mask, r_period};

    // gclk period index, wraps naturally at 2^PERIOD_W
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_period <= '0;
        end else if (clr) begin
            r_period <= '0;
        end else if (gclk_posedge) begin
            r_period <= r_period + C_PER_ONE;
        end
    end

    // One saturating counter per event kind
    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
        logic [CNT_W-1:0] r_cnt;

        // Count the pulse, holding at all-ones
        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                r_cnt <= '0;
            end else if (clr) begin
                r_cnt <= '0;
            end else if (w_mask[gi] && (r_cnt != C_CNT_MAX)) begin
                r_cnt <= r_cnt + C_CNT_ONE;
            end
        end

        assign w_cnt_all[gi*CNT_W +: CNT_W] = r_cnt;
    end

    assign succ_cnt = w_cnt_all[0*CNT_W +: CNT_W];
    assign lazy_cnt = w_cnt_all[1*CNT_W +: CNT_W];
    assign fail_cnt = w_cnt_all[2*CNT_W +: CNT_W];

    // Event storage; contents are only meaningful below r_level so no reset
    always_ff @(posedge sys_clk) begin
        if (w_wr_en && !clr) begin
            r_mem[r_wptr] <= w_entry;
        end
    end

    // Read/write pointers and occupancy; clr discards any same-cycle pop
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else if (clr) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_wr_en) begin
                r_wptr <= r_wptr + C_PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + C_PTR_ONE;
            end
            if (w_wr_en && !w_pop) begin
                r_level <= r_level + C_LVL_ONE;
            end else if (!w_wr_en && w_pop) begin
                r_level <= r_level - C_LVL_ONE;
            end
        end
    end

    // Sticky flag for an event lost to a full FIFO
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_overflow <= 1'b0;
        end else if (clr) begin
            r_overflow <= 1'b0;
        end else if (w_push && w_full && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

    // Verdict state register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= V_NONE;
        end else if (clr) begin
            r_state <= V_NONE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Verdict next state: any fail dominates, FAIL is absorbing
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            V_NONE: begin
                if (fail) begin
                    w_state_nxt = V_FAIL;
                end else if (succ || lazy_succ) begin
                    w_state_nxt = V_PASS;
                end
            end
            V_PASS: begin
                if (fail) begin
                    w_state_nxt = V_FAIL;
                end
            end
            V_FAIL:  w_state_nxt = V_FAIL;
            default: w_state_nxt = V_NONE;
        endcase
    end

    assign verdict    = r_state;
    assign evt_valid  = (r_level != '0);
    // Head is presented directly (fall-through); zero when empty
    assign evt_data   = evt_valid ? r_mem[r_rptr] : '0;
    assign fifo_level = r_level;
    assign overflow   = r_overflow;

endmodule
`default_nettype wire
